// File: rtl/wb_uart_fifo_core.sv
// Wishbone-slave UART: TX/RX FIFOs, programmable oversampling divisor, optional parity, two stop bits.
// Single clock domain; srx_pad_i is the only asynchronous input and passes through a 2-flop synchroniser.

module wb_uart_fifo_core_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module wb_uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int RESET_DIV  = 27
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic [2:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_stb_i,
    input  logic       wb_cyc_i,
    output logic       wb_ack_o,
    output logic       int_o,
    input  logic       srx_pad_i,
    output logic       stx_pad_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_STOP2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    function automatic logic [DIV_WIDTH-1:0] div_eff(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? DIV_WIDTH'(1) : d;
    endfunction

    // Bus handshake: an access is stb&cyc while ack is low; ack follows one cycle later for one cycle.
    // Register side effects commit on the edge that raises ack, so each access acts exactly once.
    logic access, wr, rd;
    assign access = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr     = access & wb_we_i;
    assign rd     = access & ~wb_we_i;

    logic [7:0]           ctrl_q;
    logic [DIV_WIDTH-1:0] div_q, tick_cnt;
    logic [15:0]          div_ext, div_new16;
    logic                 div_wr, tick;
    logic                 ovr_q, fe_q, pe_q, int_q;

    wire tx_en     = ctrl_q[0];
    wire rx_en     = ctrl_q[1];
    wire ie_rx     = ctrl_q[2];
    wire ie_txidle = ctrl_q[3];
    wire ie_err    = ctrl_q[4];
    wire par_en    = ctrl_q[5];
    wire par_odd   = ctrl_q[6];
    wire two_stop  = ctrl_q[7];

    assign div_ext = 16'(div_q);
    assign div_wr  = wr & ((wb_adr_i == 3'd3) | (wb_adr_i == 3'd4));

    always_comb begin
        div_new16 = div_ext;
        if (wb_adr_i == 3'd3) div_new16[7:0]  = wb_dat_i;
        else                  div_new16[15:8] = wb_dat_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ctrl_q   <= 8'h03;
            div_q    <= DIV_WIDTH'(RESET_DIV);
            tick_cnt <= '0;
        end else begin
            if (wr && wb_adr_i == 3'd2) ctrl_q <= wb_dat_i;
            if (div_wr) begin
                div_q    <= div_new16[DIV_WIDTH-1:0];
                tick_cnt <= div_eff(div_new16[DIV_WIDTH-1:0]) - DIV_WIDTH'(1);
            end else if (tick_cnt == '0) begin
                tick_cnt <= div_eff(div_q) - DIV_WIDTH'(1);
            end else begin
                tick_cnt <= tick_cnt - DIV_WIDTH'(1);
            end
        end
    end
    assign tick = (tick_cnt == '0);

    // FIFOs
    logic                 tx_push, tx_pop, tx_empty, tx_full;
    logic [DATA_BITS-1:0] tx_rdata, rx_rdata, rx_shift;
    logic [CW-1:0]        tx_cnt, rx_cnt;
    logic                 rx_push, rx_pop, rx_pop_ok, rx_empty, rx_full;

    assign tx_push   = wr & (wb_adr_i == 3'd0) & ~tx_full;
    assign rx_pop    = rd & (wb_adr_i == 3'd0);
    assign rx_pop_ok = rx_pop & ~rx_empty;

    wb_uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(wb_clk_i), .rst_n(wb_rst_ni), .push(tx_push), .wdata(wb_dat_i[DATA_BITS-1:0]),
        .pop(tx_pop), .rdata(tx_rdata), .count(tx_cnt), .empty(tx_empty), .full(tx_full)
    );

    wb_uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(wb_clk_i), .rst_n(wb_rst_ni), .push(rx_push), .wdata(rx_shift),
        .pop(rx_pop), .rdata(rx_rdata), .count(rx_cnt), .empty(rx_empty), .full(rx_full)
    );

    // TX FSM
    tx_state_t            tx_state, tx_next;
    logic [3:0]           tx_tcnt;
    logic [2:0]           tx_bidx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_bit_end, tx_go, tx_line, tx_idle;

    assign tx_bit_end = tick & (tx_tcnt == 4'd15);
    assign tx_go      = tick & tx_en & ~tx_empty;
    assign tx_pop     = (tx_state == TX_IDLE) & tx_go;
    assign tx_idle    = tx_empty & (tx_state == TX_IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) tx_state <= TX_IDLE;
        else            tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_go) tx_next = TX_START;
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bidx == 3'(DATA_BITS-1))
                           tx_next = par_en ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_end) tx_next = two_stop ? TX_STOP2 : TX_IDLE;
            TX_STOP2:  if (tx_bit_end) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift[0];
            TX_PARITY: tx_line = tx_par;
            default:   tx_line = 1'b1;
        endcase
    end
    assign stx_pad_o = tx_line;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tx_tcnt  <= '0;
            tx_bidx  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            tx_tcnt <= '0;
            tx_bidx <= '0;
            if (tx_pop) begin
                tx_shift <= tx_rdata;
                tx_par   <= (^tx_rdata) ^ par_odd;
            end
        end else if (tick) begin
            tx_tcnt <= tx_tcnt + 4'd1;
            if (tx_bit_end && tx_state == TX_DATA) begin
                tx_shift <= tx_shift >> 1;
                tx_bidx  <= tx_bidx + 3'd1;
            end
        end
    end

    // RX synchroniser and FSM
    rx_state_t  rx_state, rx_next;
    logic       rx_s1, rx_s2, rx_prev, rx_fall;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bidx;
    logic       rx_pbit, rx_mid, rx_bit_end;
    logic       ovr_set, fe_set, pe_set, stat_clr;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= srx_pad_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall    = rx_prev & ~rx_s2;
    assign rx_mid     = tick & (rx_tcnt == 4'd7);
    assign rx_bit_end = tick & (rx_tcnt == 4'd15);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) rx_state <= RX_IDLE;
        else            rx_state <= rx_next;
    end

    // The frame ends at the stop-bit sample so a back-to-back start edge is never missed.
    always_comb begin
        rx_next = rx_state;
        if (rx_state != RX_IDLE && !rx_en) begin
            rx_next = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:   if (rx_en && rx_fall) rx_next = RX_START;
                RX_START:  if (rx_mid && rx_s2) rx_next = RX_IDLE;
                           else if (rx_bit_end) rx_next = RX_DATA;
                RX_DATA:   if (rx_bit_end && rx_bidx == 3'(DATA_BITS-1))
                               rx_next = par_en ? RX_PARITY : RX_STOP;
                RX_PARITY: if (rx_bit_end) rx_next = RX_STOP;
                RX_STOP:   if (rx_mid) rx_next = RX_IDLE;
                default:   rx_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_push = (rx_state == RX_STOP) & rx_mid & rx_en;
        fe_set  = rx_push & ~rx_s2;
        pe_set  = rx_push & par_en & (rx_pbit != ((^rx_shift) ^ par_odd));
        ovr_set = rx_push & rx_full & ~rx_pop_ok;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_tcnt  <= '0;
            rx_bidx  <= '0;
            rx_shift <= '0;
            rx_pbit  <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            rx_tcnt <= '0;
            rx_bidx <= '0;
        end else if (tick) begin
            rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_mid && rx_state == RX_DATA)   rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
            if (rx_mid && rx_state == RX_PARITY) rx_pbit  <= rx_s2;
            if (rx_bit_end && rx_state == RX_DATA) rx_bidx <= rx_bidx + 3'd1;
        end
    end

    // Sticky status, read data, interrupt
    assign stat_clr = rd & (wb_adr_i == 3'd1);

    logic [7:0] rdata;
    always_comb begin
        rdata = 8'h00;
        case (wb_adr_i)
            3'd0:    rdata = rx_empty ? 8'h00 : 8'(rx_rdata);
            3'd1:    rdata = {2'b00, pe_q, fe_q, ovr_q, tx_idle, tx_full, ~rx_empty};
            3'd2:    rdata = ctrl_q;
            3'd3:    rdata = div_ext[7:0];
            3'd4:    rdata = div_ext[15:8];
            3'd5:    rdata = 8'(rx_cnt);
            3'd6:    rdata = 8'(tx_cnt);
            default: rdata = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 8'h00;
            ovr_q    <= 1'b0;
            fe_q     <= 1'b0;
            pe_q     <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            wb_ack_o <= access;
            wb_dat_o <= rd ? rdata : 8'h00;
            ovr_q    <= (ovr_q & ~stat_clr) | ovr_set;
            fe_q     <= (fe_q & ~stat_clr) | fe_set;
            pe_q     <= (pe_q & ~stat_clr) | pe_set;
            int_q    <= (ie_rx & ~rx_empty) | (ie_txidle & tx_idle) | (ie_err & (ovr_q | fe_q | pe_q));
        end
    end
    assign int_o = int_q;
endmodule

// File: tb/tb_wb_uart_fifo_core.sv
// Directed bench for wb_uart_fifo_core: register vector table, then TX waveform, loopback,
// overrun, parity/framing, interrupt and mid-frame reset sequences.

module tb_wb_uart_fifo_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] adr = '0;
    logic [7:0] dat_i = '0;
    logic       we = 1'b0, stb = 1'b0, cyc = 1'b0;
    logic [7:0] dat_o;
    logic       ack, intr, stx, srx;
    logic       drv_rx = 1'b1;
    logic       loop = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    assign srx = loop ? stx : drv_rx;

    always #5 clk = ~clk;

    wb_uart_fifo_core dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack), .int_o(intr),
        .srx_pad_i(srx), .stx_pad_o(stx)
    );

    typedef struct {
        logic [2:0] adr;
        logic       we;
        logic [7:0] wdat;
        logic [7:0] exp;
        logic       chk;
    } vec_t;
    vec_t vecs[21];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [7:0] d, output logic [7:0] q);
        int n;
        @(posedge clk); #1;
        adr = a; we = w; dat_i = d; stb = 1'b1; cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        check("bus_ack", ack, 1);
        q = dat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] q;
        wb_xfer(a, 1'b1, d, q);
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] e);
        logic [7:0] q;
        wb_xfer(a, 1'b0, 8'h00, q);
        check(nm, q, e);
    endtask

    // One serial bit at DIV=4: 16 ticks x 4 clocks.
    task automatic send_bit(input logic b);
        drv_rx = b;
        repeat (64) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic pbit, input logic stopb);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(pbit);
        send_bit(stopb);
        send_bit(1'b1);
    endtask

    initial begin
        logic [7:0] q;
        logic [7:0] e;
        logic [9:0] fr;
        int n;

        // reset
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stx", stx, 1);
        check("rst_ack", ack, 0);
        check("rst_dat", dat_o, 8'h00);
        check("rst_int", intr, 0);
        @(negedge clk) rst_n = 1'b1;

        // register vectors
        vecs[0]  = '{3'd2, 1'b0, 8'h00, 8'h03, 1'b1};
        vecs[1]  = '{3'd3, 1'b0, 8'h00, 8'h1B, 1'b1};
        vecs[2]  = '{3'd4, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[3]  = '{3'd1, 1'b0, 8'h00, 8'h04, 1'b1};
        vecs[4]  = '{3'd5, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{3'd6, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{3'd7, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[7]  = '{3'd0, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{3'd2, 1'b1, 8'h5A, 8'h00, 1'b0};
        vecs[9]  = '{3'd2, 1'b0, 8'h00, 8'h5A, 1'b1};
        vecs[10] = '{3'd4, 1'b1, 8'h12, 8'h00, 1'b0};
        vecs[11] = '{3'd3, 1'b1, 8'h34, 8'h00, 1'b0};
        vecs[12] = '{3'd3, 1'b0, 8'h00, 8'h34, 1'b1};
        vecs[13] = '{3'd4, 1'b0, 8'h00, 8'h12, 1'b1};
        vecs[14] = '{3'd7, 1'b1, 8'hFF, 8'h00, 1'b0};
        vecs[15] = '{3'd7, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[16] = '{3'd2, 1'b0, 8'h00, 8'h5A, 1'b1};
        vecs[17] = '{3'd2, 1'b1, 8'h03, 8'h00, 1'b0};
        vecs[18] = '{3'd4, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[19] = '{3'd3, 1'b1, 8'h01, 8'h00, 1'b0};
        vecs[20] = '{3'd3, 1'b0, 8'h00, 8'h01, 1'b1};
        for (int i = 0; i < 21; i++) begin
            wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].wdat, q);
            if (vecs[i].chk) check($sformatf("vec%0d", i), q, vecs[i].exp);
        end

        // TX waveform at DIV=1: 0x55 framed as start, LSB-first data, stop
        wr(3'd0, 8'h55);
        n = 0;
        while (stx !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("tx_start_seen", stx, 0);
        fr = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 160; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("tx_bit%0d", i / 16), stx, fr[i / 16]);
        end
        @(posedge clk); #1;
        check("tx_after_stop", stx, 1);
        rd_chk("tx_stat_idle", 3'd1, 8'h04);

        // loopback at DIV=4
        wr(3'd3, 8'h04);
        loop = 1'b1;
        wr(3'd0, 8'hA3);
        wr(3'd0, 8'h0F);
        repeat (1500) @(posedge clk);
        rd_chk("lb_rxcnt2", 3'd5, 8'h02);
        rd_chk("lb_data0", 3'd0, 8'hA3);
        rd_chk("lb_data1", 3'd0, 8'h0F);
        rd_chk("lb_data_empty", 3'd0, 8'h00);
        rd_chk("lb_rxcnt0", 3'd5, 8'h00);
        rd_chk("lb_stat", 3'd1, 8'h04);

        // overrun: 17 bytes into a 16-deep RX FIFO
        for (int i = 0; i < 17; i++) begin
            e = 8'(i * 7 + 3);
            wr(3'd0, e);
            if (i < 16) exp_q.push_back(e);
        end
        repeat (11200) @(posedge clk);
        rd_chk("ovr_rxcnt", 3'd5, 8'h10);
        rd_chk("ovr_stat", 3'd1, 8'h0D);
        rd_chk("ovr_stat_cleared", 3'd1, 8'h05);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_chk("ovr_drain", 3'd0, e);
        end
        rd_chk("ovr_rxcnt0", 3'd5, 8'h00);
        loop = 1'b0;

        // parity and framing via injected frames, even parity
        wr(3'd2, 8'h23);
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        rd_chk("par_err_stat", 3'd1, 8'h25);
        rd_chk("par_err_data", 3'd0, 8'h01);
        rd_chk("par_err_cleared", 3'd1, 8'h04);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        rd_chk("frame_err_stat", 3'd1, 8'h15);
        rd_chk("frame_err_data", 3'd0, 8'h01);
        send_frame(8'h96, 1'b1, 1'b0, 1'b1);
        rd_chk("par_ok_stat", 3'd1, 8'h05);
        rd_chk("par_ok_data", 3'd0, 8'h96);

        // TX-idle interrupt
        wr(3'd2, 8'h0B);
        repeat (3) @(posedge clk);
        #1;
        check("int_idle_high", intr, 1);
        wr(3'd0, 8'h3C);
        @(posedge clk); #1;
        check("int_drop", intr, 0);
        n = 0;
        while (intr !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("int_return", intr, 1);
        check("int_return_window", (n >= 636 && n <= 650), 1);

        // asynchronous reset mid-frame
        wr(3'd0, 8'h00);
        wr(3'd0, 8'h00);
        wr(3'd0, 8'h00);
        repeat (90) @(posedge clk);
        #1;
        rd_chk("pre_rst_txcnt", 3'd6, 8'h02);
        check("pre_rst_stx_low", stx, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stx", stx, 1);
        check("rst_mid_int", intr, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rd_chk("post_rst_txcnt", 3'd6, 8'h00);
        rd_chk("post_rst_ctrl", 3'd2, 8'h03);
        rd_chk("post_rst_div_lo", 3'd3, 8'h1B);
        rd_chk("post_rst_div_hi", 3'd4, 8'h00);
        rd_chk("post_rst_stat", 3'd1, 8'h04);
        repeat (50) @(posedge clk);
        #1;
        check("post_rst_stx", stx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
